// File: rtl/lsu_ctrl.sv
// Load/store control unit between the MEM stage and data_mem: one request per
// transaction, misaligned split into byte accesses. Option: LSU_MISALIGN_TRAP_EN.

package rv_pkg;
    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HWORD = 2'd1,
        WORD  = 2'd2
    } mem_op_sz_e;
endpackage

module lsu_ctrl #(
    parameter int unsigned MemoryBytesSize = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_we,
    input  logic [31:0]        i_req_addr,
    input  logic [31:0]        i_req_wdata,
    input  rv_pkg::mem_op_sz_e i_req_size,
    input  logic               i_req_unsigned,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [31:0]        o_rsp_rdata,
    output logic               o_rsp_err,
    output logic               o_mem_we,
    output logic               o_mem_re,
    output logic [31:0]        o_mem_addr,
    output logic [31:0]        o_mem_data,
    output rv_pkg::mem_op_sz_e o_mem_size,
    input  logic [31:0]        i_mem_data
);
    import rv_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_SPLIT  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;
`endif

    function automatic logic [2:0] size_nbytes(input mem_op_sz_e sz);
        logic [2:0] n;
        case (sz)
            BYTE:    n = 3'd1;
            HWORD:   n = 3'd2;
            WORD:    n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic is_misaligned(input mem_op_sz_e sz, input logic [1:0] lsb);
        logic m;
        case (sz)
            HWORD:   m = lsb[0];
            WORD:    m = (lsb != 2'd0);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] d, input mem_op_sz_e sz,
                                                input logic uns);
        logic [31:0] r;
        case (sz)
            BYTE:    r = {{24{d[7] & ~uns}}, d[7:0]};
            HWORD:   r = {{16{d[15] & ~uns}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    mem_op_sz_e  size_q, size_d;
    logic        uns_q, uns_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    mem_op_sz_e  mem_size_q, mem_size_d;
`ifndef LSU_MISALIGN_TRAP_EN
    logic [1:0]  k_q, k_d;
    logic [1:0]  k_nxt_s;
    logic [31:0] asm_q, asm_d;
    logic [31:0] asm_s;
    logic        split_last_s;
`endif

    logic [2:0]  nbytes_s;
    logic        misalign_s;
    logic [32:0] sum_s;
    logic        req_err_s;

    // Request classification: size decode, alignment and range check (no 32-bit wrap).
    always_comb begin
        nbytes_s   = size_nbytes(i_req_size);
        misalign_s = is_misaligned(i_req_size, i_req_addr[1:0]);
        sum_s      = {1'b0, i_req_addr} + {30'd0, nbytes_s};
`ifdef LSU_MISALIGN_TRAP_EN
        req_err_s  = (nbytes_s == 3'd0) || (sum_s > 33'(MemoryBytesSize)) || misalign_s;
`else
        req_err_s  = (nbytes_s == 3'd0) || (sum_s > 33'(MemoryBytesSize));
`endif
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = 32'd0;
        mem_data_d  = 32'd0;
        mem_size_d  = BYTE;
`ifndef LSU_MISALIGN_TRAP_EN
        k_d          = k_q;
        asm_d        = asm_q;
        k_nxt_s      = k_q + 2'd1;
        asm_s        = asm_q;
        asm_s[{k_q, 3'b000} +: 8] = i_mem_data[7:0];
        split_last_s = ({1'b0, k_q} == (size_nbytes(size_q) - 3'd1));
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid && req_ready_q) begin
                    we_d    = i_req_we;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    if (req_err_s) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rdata_d     = 32'd0;
                        err_d       = 1'b1;
`ifndef LSU_MISALIGN_TRAP_EN
                    end else if (misalign_s) begin
                        state_d    = ST_SPLIT;
                        k_d        = 2'd0;
                        asm_d      = 32'd0;
                        mem_we_d   = i_req_we;
                        mem_re_d   = ~i_req_we;
                        mem_addr_d = i_req_addr;
                        mem_data_d = {24'd0, i_req_wdata[7:0]};
                        mem_size_d = BYTE;
`endif
                    end else begin
                        state_d    = ST_ACCESS;
                        mem_we_d   = i_req_we;
                        mem_re_d   = ~i_req_we;
                        mem_addr_d = i_req_addr;
                        mem_data_d = i_req_wdata;
                        mem_size_d = i_req_size;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                err_d       = 1'b0;
                rdata_d     = we_q ? 32'd0 : load_extend(i_mem_data, size_q, uns_q);
            end
`ifndef LSU_MISALIGN_TRAP_EN
            ST_SPLIT: begin
                asm_d = asm_s;
                if (split_last_s) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    err_d       = 1'b0;
                    rdata_d     = we_q ? 32'd0 : load_extend(asm_s, size_q, uns_q);
                end else begin
                    k_d        = k_nxt_s;
                    mem_we_d   = we_q;
                    mem_re_d   = ~we_q;
                    mem_addr_d = addr_q + {30'd0, k_nxt_s};
                    mem_data_d = {24'd0, wdata_q[{k_nxt_s, 3'b000} +: 8]};
                    mem_size_d = BYTE;
                end
            end
`endif
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rdata_d     = 32'd0;
                    err_d       = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                rdata_d     = 32'd0;
                err_d       = 1'b0;
            end
        endcase
        // Ready tracks the state being entered so no accept overlaps a response.
        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset abandons any in-flight split.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            size_q      <= BYTE;
            uns_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_data_q  <= 32'd0;
            mem_size_q  <= BYTE;
`ifndef LSU_MISALIGN_TRAP_EN
            k_q         <= 2'd0;
            asm_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_size_q  <= mem_size_d;
`ifndef LSU_MISALIGN_TRAP_EN
            k_q         <= k_d;
            asm_q       <= asm_d;
`endif
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_re    = mem_re_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_data  = mem_data_q;
    assign o_mem_size  = mem_size_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, hand-written corner
// sequences, and random traffic against a byte-array reference model.

module tb_lsu_ctrl;
    import rv_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [31:0] i_req_addr = 32'd0;
    logic [31:0] i_req_wdata = 32'd0;
    mem_op_sz_e  i_req_size = BYTE;
    logic        i_req_unsigned = 1'b0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b1;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_mem_we;
    logic        o_mem_re;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    mem_op_sz_e  o_mem_size;
    logic [31:0] i_mem_data;

    lsu_ctrl #(.MemoryBytesSize(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .o_mem_addr(o_mem_addr),
        .o_mem_data(o_mem_data), .o_mem_size(o_mem_size), .i_mem_data(i_mem_data)
    );

    always #5 i_clk = ~i_clk;

    // Attached 16-byte data memory: combinational read, write on rising edge.
    logic [7:0] tb_mem [16];
    logic       clr_mem = 1'b0;
    logic [7:0] b0, b1, b2, b3;
    assign b0 = (o_mem_addr < 32'd16) ? tb_mem[o_mem_addr[3:0]] : 8'd0;
    assign b1 = (o_mem_addr < 32'd15) ? tb_mem[o_mem_addr[3:0] + 4'd1] : 8'd0;
    assign b2 = (o_mem_addr < 32'd14) ? tb_mem[o_mem_addr[3:0] + 4'd2] : 8'd0;
    assign b3 = (o_mem_addr < 32'd13) ? tb_mem[o_mem_addr[3:0] + 4'd3] : 8'd0;
    always_comb begin
        case (o_mem_size)
            BYTE:    i_mem_data = {24'd0, b0};
            HWORD:   i_mem_data = {16'd0, b1, b0};
            default: i_mem_data = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge i_clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= 8'd0;
        end else if (o_mem_we) begin
            if (o_mem_addr < 32'd16) tb_mem[o_mem_addr[3:0]] <= o_mem_data[7:0];
            if (o_mem_size != BYTE && o_mem_addr < 32'd15) tb_mem[o_mem_addr[3:0] + 4'd1] <= o_mem_data[15:8];
            if (o_mem_size == WORD && o_mem_addr < 32'd13) begin
                tb_mem[o_mem_addr[3:0] + 4'd2] <= o_mem_data[23:16];
                tb_mem[o_mem_addr[3:0] + 4'd3] <= o_mem_data[31:24];
            end
        end
    end

    int wr_cnt = 0;
    int rd_cnt = 0;
    always @(negedge i_clk) begin
        if (o_mem_we) wr_cnt <= wr_cnt + 1;
        if (o_mem_re) rd_cnt <= rd_cnt + 1;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic pulse_clr();
        clr_mem = 1'b1;
        @(posedge i_clk); #1;
        clr_mem = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] sz, input logic uns);
        int n;
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_addr     = addr;
        i_req_wdata    = wdata;
        i_req_size     = mem_op_sz_e'(sz);
        i_req_unsigned = uns;
        n = 0;
        while (!o_req_ready && n < 20) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (!o_req_ready) chk("req_ready_timeout", 32'(o_req_ready), 32'd1);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] sz, input logic uns,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int nwr, output int nrd);
        int w0, r0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        issue(we, addr, wdata, sz, uns);
        lat = 1;
        while (!o_rsp_valid && lat < 20) begin
            @(posedge i_clk); #1;
            lat++;
        end
        rdata = o_rsp_rdata;
        err   = o_rsp_err;
        @(posedge i_clk); #1;
        nwr = wr_cnt - w0;
        nrd = rd_cnt - r0;
    endtask

    // Reference model: memory as a plain byte array, results from the access rules.
    logic [7:0] ref_mem [16];

    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] sz, input logic uns,
                         output logic [31:0] rd, output logic err,
                         output int lat, output int nwr, output int nrd);
        int nb;
        logic mis;
        logic [32:0] sum;
        logic [31:0] val, msk;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        mis = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'd0);
        sum = {1'b0, addr} + 33'(nb);
        err = (nb == 0) || (sum > 33'd16);
`ifdef LSU_MISALIGN_TRAP_EN
        err = err || mis;
`endif
        rd  = 32'd0;
        lat = err ? 1 : (mis ? 1 + nb : 2);
        nwr = 0;
        nrd = 0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[int'(addr[4:0]) + i] = 8'(wdata >> (8 * i));
                nwr = mis ? nb : 1;
            end else begin
                val = 32'd0;
                for (int i = 0; i < nb; i++) val = val | (32'(ref_mem[int'(addr[4:0]) + i]) << (8 * i));
                if (nb < 4 && !uns && val[8 * nb - 1]) begin
                    msk = (32'd1 << (8 * nb)) - 32'd1;
                    val = val | ~msk;
                end
                rd  = val;
                nrd = mis ? nb : 1;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] sz, input logic uns, input logic [31:0] erd,
                                input logic eerr, input int elat, input int ewr, input int erdn);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.sz = sz; v.uns = uns;
        v.exp_rdata = erd; v.exp_err = eerr; v.exp_lat = elat; v.exp_wr = ewr; v.exp_rd = erdn;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [31:0] rdata, erd, held;
        logic err, eerr;
        int lat, nwr, nrd, elat, ewr, erdn, n;
        logic rwe, runs;
        logic [31:0] raddr, rwd;
        logic [1:0] rsz;

        // Directed vectors: {we, addr, wdata, size, uns, rdata, err, latency, writes, reads}
        vecs.push_back(mk(1'b1, 32'd4,  32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0, 2, 1, 0));
        vecs.push_back(mk(1'b0, 32'd4,  32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 2, 0, 1));
        vecs.push_back(mk(1'b1, 32'd7,  32'h00000080, 2'd0, 1'b0, 32'h0,        1'b0, 2, 1, 0));
        vecs.push_back(mk(1'b0, 32'd7,  32'h0,        2'd0, 1'b0, 32'hFFFFFF80, 1'b0, 2, 0, 1));
        vecs.push_back(mk(1'b0, 32'd7,  32'h0,        2'd0, 1'b1, 32'h00000080, 1'b0, 2, 0, 1));
        vecs.push_back(mk(1'b1, 32'd6,  32'h00008001, 2'd1, 1'b0, 32'h0,        1'b0, 2, 1, 0));
        vecs.push_back(mk(1'b0, 32'd6,  32'h0,        2'd1, 1'b0, 32'hFFFF8001, 1'b0, 2, 0, 1));
        vecs.push_back(mk(1'b0, 32'd6,  32'h0,        2'd1, 1'b1, 32'h00008001, 1'b0, 2, 0, 1));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b1, 32'd5,  32'h11223344, 2'd2, 1'b0, 32'h0,        1'b1, 1, 0, 0));
        vecs.push_back(mk(1'b0, 32'd5,  32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 1, 0, 0));
        vecs.push_back(mk(1'b1, 32'd9,  32'h0000A5C3, 2'd1, 1'b0, 32'h0,        1'b1, 1, 0, 0));
        vecs.push_back(mk(1'b0, 32'd9,  32'h0,        2'd1, 1'b0, 32'h0,        1'b1, 1, 0, 0));
`else
        vecs.push_back(mk(1'b1, 32'd5,  32'h11223344, 2'd2, 1'b0, 32'h0,        1'b0, 5, 4, 0));
        vecs.push_back(mk(1'b0, 32'd5,  32'h0,        2'd2, 1'b0, 32'h11223344, 1'b0, 5, 0, 4));
        vecs.push_back(mk(1'b1, 32'd9,  32'h0000A5C3, 2'd1, 1'b0, 32'h0,        1'b0, 3, 2, 0));
        vecs.push_back(mk(1'b0, 32'd9,  32'h0,        2'd1, 1'b0, 32'hFFFFA5C3, 1'b0, 3, 0, 2));
`endif
        vecs.push_back(mk(1'b0, 32'd14, 32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 1, 0, 0));
        vecs.push_back(mk(1'b1, 32'd13, 32'hCAFEBABE, 2'd2, 1'b0, 32'h0,        1'b1, 1, 0, 0));
        vecs.push_back(mk(1'b0, 32'hFFFFFFFE, 32'h0,  2'd2, 1'b0, 32'h0,        1'b1, 1, 0, 0));
        vecs.push_back(mk(1'b1, 32'd12, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0,        1'b0, 2, 1, 0));
        vecs.push_back(mk(1'b0, 32'd12, 32'h0,        2'd2, 1'b0, 32'hCAFEF00D, 1'b0, 2, 0, 1));
        vecs.push_back(mk(1'b0, 32'd0,  32'h0,        2'd3, 1'b0, 32'h0,        1'b1, 1, 0, 0));

        // Reset state
        #1;
        chk("rst_req_ready", 32'(o_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_mem_strobes", {30'd0, o_mem_we, o_mem_re}, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_size", 32'(o_mem_size), 32'(BYTE));
        clr_mem = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst   = 1'b1;
        clr_mem = 1'b0;
        @(posedge i_clk); #1;
        chk("post_rst_ready", 32'(o_req_ready), 32'd1);

        foreach (vecs[i]) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sz, vecs[i].uns,
                   rdata, err, lat, nwr, nrd);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_writes", i), 32'(nwr), 32'(vecs[i].exp_wr));
            chk($sformatf("vec%0d_reads", i), 32'(nrd), 32'(vecs[i].exp_rd));
        end

        // Response back-pressure: outputs hold while i_rsp_ready is low
        do_txn(1'b1, 32'd0, 32'h13579BDF, 2'd2, 1'b0, rdata, err, lat, nwr, nrd);
        i_rsp_ready = 1'b0;
        issue(1'b0, 32'd0, 32'h0, 2'd2, 1'b0);
        n = 1;
        while (!o_rsp_valid && n < 20) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("bp_latency", 32'(n), 32'd2);
        for (int c = 0; c < 3; c++) begin
            chk("bp_valid", 32'(o_rsp_valid), 32'd1);
            chk("bp_rdata", o_rsp_rdata, 32'h13579BDF);
            chk("bp_err", 32'(o_rsp_err), 32'd0);
            chk("bp_req_ready", 32'(o_req_ready), 32'd0);
            chk("bp_strobes", {30'd0, o_mem_we, o_mem_re}, 32'd0);
            @(posedge i_clk); #1;
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("bp_release_valid", 32'(o_rsp_valid), 32'd0);
        chk("bp_release_ready", 32'(o_req_ready), 32'd1);

`ifndef LSU_MISALIGN_TRAP_EN
        // Reset in the middle of a split store: written bytes stay, the rest never land
        pulse_clr();
        issue(1'b1, 32'd1, 32'hAABBCCDD, 2'd2, 1'b0);
        chk("split_b0_we", 32'(o_mem_we), 32'd1);
        chk("split_b0_addr", o_mem_addr, 32'd1);
        chk("split_b0_data", o_mem_data, 32'h000000DD);
        chk("split_b0_size", 32'(o_mem_size), 32'(BYTE));
        @(posedge i_clk); #1;
        chk("split_b1_addr", o_mem_addr, 32'd2);
        chk("split_b1_data", o_mem_data, 32'h000000CC);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        #1;
        chk("midrst_strobes", {30'd0, o_mem_we, o_mem_re}, 32'd0);
        chk("midrst_addr", o_mem_addr, 32'd0);
        chk("midrst_data", o_mem_data, 32'd0);
        chk("midrst_valid", 32'(o_rsp_valid), 32'd0);
        chk("midrst_ready", 32'(o_req_ready), 32'd0);
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        chk("midrst_ready_after", 32'(o_req_ready), 32'd1);
        chk("midrst_mem1", 32'(tb_mem[1]), 32'hDD);
        chk("midrst_mem2", 32'(tb_mem[2]), 32'hCC);
        chk("midrst_mem3", 32'(tb_mem[3]), 32'h00);
        chk("midrst_mem4", 32'(tb_mem[4]), 32'h00);
`endif

        // Random traffic against the reference model
        pulse_clr();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'd0;
        for (int t = 0; t < 80; t++) begin
            rwe   = 1'($urandom_range(0, 1));
            raddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 19));
            rwd   = $urandom;
            n     = $urandom_range(0, 15);
            rsz   = (n == 15) ? 2'd3 : 2'(n % 3);
            runs  = 1'($urandom_range(0, 1));
            model(rwe, raddr, rwd, rsz, runs, erd, eerr, elat, ewr, erdn);
            do_txn(rwe, raddr, rwd, rsz, runs, rdata, err, lat, nwr, nrd);
            chk($sformatf("rnd%0d_rdata", t), rdata, erd);
            chk($sformatf("rnd%0d_err", t), 32'(err), 32'(eerr));
            chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(elat));
            chk($sformatf("rnd%0d_writes", t), 32'(nwr), 32'(ewr));
            chk($sformatf("rnd%0d_reads", t), 32'(nrd), 32'(erdn));
        end
        held = 32'd0;
        for (int i = 0; i < 16; i++) held = held + 32'(tb_mem[i] != ref_mem[i]);
        chk("rnd_final_memory_diffs", held, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
